// File: rtl/int_ctrl_prio.sv
// Prioritised edge-triggered interrupt controller with per-channel mask and vector output.
// Define INT_CTRL_NESTING_EN to let higher-priority channels preempt lower ones in service.
module int_ctrl_prio #(
   parameter int unsigned       N_CH       = 4,
   parameter int unsigned       PC_W       = 10,
   parameter logic [PC_W-1:0]   VEC_BASE   = 10'h3F0,
   parameter int unsigned       VEC_STRIDE = 1,
   parameter logic [N_CH-1:0]   MASK_RST   = '1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] int_req,
   input  logic            mask_we,
   input  logic [N_CH-1:0] mask_d,
   input  logic            int_ack,
   input  logic            fin_int,
   output logic            irq_uc,
   output logic [PC_W-1:0] vector,
   output logic [N_CH-1:0] pending,
   output logic [N_CH-1:0] in_service
);

   logic [N_CH-1:0] req_q;
   logic [N_CH-1:0] pend_q, pend_d;
   logic [N_CH-1:0] ins_q, ins_d;
   logic [N_CH-1:0] mask_q;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] eligible;
   logic [N_CH-1:0] sel_oh;
   logic [N_CH-1:0] clr;
   int unsigned     sel_idx;
   logic            irq;

   assign rise     = int_req & ~req_q;
   assign eligible = pend_q & mask_q;

   always_comb begin
      sel_idx = 0;
      sel_oh  = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_idx   = i;
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
   end

   assign vector = VEC_BASE + PC_W'(sel_idx * VEC_STRIDE);

`ifdef INT_CTRL_NESTING_EN
   int unsigned     cur_idx;
   logic [N_CH-1:0] cur_oh;

   // cur is the highest-priority channel in service, or N_CH when nothing is.
   always_comb begin
      cur_idx = N_CH;
      cur_oh  = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (ins_q[i]) begin
            cur_idx   = i;
            cur_oh    = '0;
            cur_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      irq   = (|eligible) && (sel_idx < cur_idx);
      clr   = '0;
      ins_d = ins_q;
      if (fin_int) begin
         ins_d = ins_d & ~cur_oh;
      end
      if (int_ack && irq) begin
         clr   = sel_oh;
         ins_d = ins_d | sel_oh;
      end
   end
`else
   typedef enum logic [0:0] {StIdle, StService} state_e;
   state_e state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      irq     = 1'b0;
      clr     = '0;
      ins_d   = ins_q;
      unique case (state_q)
         StIdle: begin
            irq = |eligible;
            if (int_ack && irq) begin
               clr     = sel_oh;
               ins_d   = sel_oh;
               state_d = StService;
            end
         end
         StService: begin
            if (fin_int) begin
               ins_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end
`endif

   // A new edge on the acknowledged channel wins over its clear.
   assign pend_d = (pend_q & ~clr) | rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q  <= '0;
         pend_q <= '0;
         ins_q  <= '0;
         mask_q <= MASK_RST;
      end else begin
         req_q  <= int_req;
         pend_q <= pend_d;
         ins_q  <= ins_d;
         if (mask_we) begin
            mask_q <= mask_d;
         end
      end
   end

   assign irq_uc     = irq;
   assign pending    = pend_q;
   assign in_service = ins_q;

endmodule

// File: tb/tb_int_ctrl_prio.sv
// Self-checking bench for int_ctrl_prio: directed scenarios plus randomized traffic
// compared against a priority/queue-level reference model.
module tb_int_ctrl_prio;

   localparam int        N  = 4;
   localparam int        PW = 10;
   localparam logic [9:0] VB = 10'h3F0;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  int_req = '0;
   logic          mask_we = 1'b0;
   logic [N-1:0]  mask_d = '0;
   logic          int_ack = 1'b0;
   logic          fin_int = 1'b0;
   logic          irq_uc;
   logic [PW-1:0] vector;
   logic [N-1:0]  pending;
   logic [N-1:0]  in_service;

   int n_tests = 0;
   int n_fail  = 0;

   int_ctrl_prio #(
      .N_CH      (N),
      .PC_W      (PW),
      .VEC_BASE  (VB),
      .VEC_STRIDE(1),
      .MASK_RST  (4'b1111)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .int_req   (int_req),
      .mask_we   (mask_we),
      .mask_d    (mask_d),
      .int_ack   (int_ack),
      .fin_int   (fin_int),
      .irq_uc    (irq_uc),
      .vector    (vector),
      .pending   (pending),
      .in_service(in_service)
   );

   always #5 clk = ~clk;

   // Reference model: sets of channels, searched by priority.
   logic [N-1:0] m_req, m_pend, m_ins, m_mask;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return N;
   endfunction

   function automatic logic exp_irq();
      int s = lowest(m_pend & m_mask);
      int c = lowest(m_ins);
`ifdef INT_CTRL_NESTING_EN
      return s < c;
`else
      return (s < N) && (m_ins == '0);
`endif
   endfunction

   function automatic logic [PW-1:0] exp_vec();
      int s = lowest(m_pend & m_mask);
      if (s == N) s = 0;
      return PW'((int'(VB) + s) % 1024);
   endfunction

   always @(posedge clk or posedge reset) begin
      int s, c;
      logic go;
      logic [N-1:0] np, ni;
      if (reset) begin
         m_req  <= '0;
         m_pend <= '0;
         m_ins  <= '0;
         m_mask <= '1;
      end else begin
         s  = lowest(m_pend & m_mask);
         c  = lowest(m_ins);
         go = exp_irq();
         np = m_pend;
         ni = m_ins;
`ifdef INT_CTRL_NESTING_EN
         if (fin_int && c < N) ni[c] = 1'b0;
         if (int_ack && go) begin
            np[s] = 1'b0;
            ni[s] = 1'b1;
         end
`else
         if (m_ins != '0) begin
            if (fin_int) ni = '0;
         end else if (int_ack && go) begin
            np[s] = 1'b0;
            ni[s] = 1'b1;
         end
`endif
         m_pend <= np | (int_req & ~m_req);
         m_ins  <= ni;
         if (mask_we) m_mask <= mask_d;
         m_req  <= int_req;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_tests++; if (irq_uc !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_uc); end
      n_tests++; if (vector !== VB) begin n_fail++; $display("FAIL reset_vec: got %h want %h", vector, VB); end
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pend: got %b want 0000", pending); end
      n_tests++; if (in_service !== 4'b0000) begin n_fail++; $display("FAIL reset_ins: got %b want 0000", in_service); end
      #21;
      reset = 1'b0;
      tick();
      n_tests++; if (irq_uc !== 1'b0) begin n_fail++; $display("FAIL reset_rel_irq: got %b want 0", irq_uc); end
   endtask

   task automatic test_basic();
      int_req = 4'b0100; tick(); int_req = '0;
      n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL basic_pend: got %b want 0100", pending); end
      n_tests++; if (irq_uc !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b want 1", irq_uc); end
      n_tests++; if (vector !== VB + 10'd2) begin n_fail++; $display("FAIL basic_vec: got %h want %h", vector, VB + 10'd2); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL basic_ack_pend: got %b want 0000", pending); end
      n_tests++; if (in_service !== 4'b0100) begin n_fail++; $display("FAIL basic_ack_ins: got %b want 0100", in_service); end
      n_tests++; if (irq_uc !== 1'b0) begin n_fail++; $display("FAIL basic_ack_irq: got %b want 0", irq_uc); end
      fin_int = 1'b1; tick(); fin_int = 1'b0;
      n_tests++; if (in_service !== 4'b0000) begin n_fail++; $display("FAIL basic_fin_ins: got %b want 0000", in_service); end
   endtask

   task automatic test_priority();
      int_req = 4'b1010; tick(); int_req = '0;
      n_tests++; if (vector !== VB + 10'd1) begin n_fail++; $display("FAIL prio_vec1: got %h want %h", vector, VB + 10'd1); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      n_tests++; if (in_service !== 4'b0010) begin n_fail++; $display("FAIL prio_ins: got %b want 0010", in_service); end
      fin_int = 1'b1; tick(); fin_int = 1'b0;
      n_tests++; if (irq_uc !== 1'b1) begin n_fail++; $display("FAIL prio_irq3: got %b want 1", irq_uc); end
      n_tests++; if (vector !== VB + 10'd3) begin n_fail++; $display("FAIL prio_vec3: got %h want %h", vector, VB + 10'd3); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      fin_int = 1'b1; tick(); fin_int = 1'b0;
   endtask

   task automatic test_mask();
      mask_we = 1'b1; mask_d = 4'b1110; tick(); mask_we = 1'b0;
      int_req = 4'b0001; tick(); int_req = '0;
      n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL mask_pend: got %b want 0001", pending); end
      n_tests++; if (irq_uc !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq_uc); end
      mask_we = 1'b1; mask_d = 4'b1111; tick(); mask_we = 1'b0;
      n_tests++; if (irq_uc !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq_uc); end
      n_tests++; if (vector !== VB) begin n_fail++; $display("FAIL mask_vec: got %h want %h", vector, VB); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      fin_int = 1'b1; tick(); fin_int = 1'b0;
   endtask

   task automatic test_service();
      int_req = 4'b0100; tick(); int_req = '0;
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      int_req = 4'b0001; tick(); int_req = '0;
`ifdef INT_CTRL_NESTING_EN
      n_tests++; if (irq_uc !== 1'b1) begin n_fail++; $display("FAIL nest_irq: got %b want 1", irq_uc); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      n_tests++; if (in_service !== 4'b0101) begin n_fail++; $display("FAIL nest_ins: got %b want 0101", in_service); end
      fin_int = 1'b1; tick(); fin_int = 1'b0;
      n_tests++; if (in_service !== 4'b0100) begin n_fail++; $display("FAIL nest_fin1: got %b want 0100", in_service); end
      fin_int = 1'b1; tick(); fin_int = 1'b0;
      n_tests++; if (in_service !== 4'b0000) begin n_fail++; $display("FAIL nest_fin2: got %b want 0000", in_service); end
`else
      n_tests++; if (irq_uc !== 1'b0) begin n_fail++; $display("FAIL svc_irq_blocked: got %b want 0", irq_uc); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      n_tests++; if (in_service !== 4'b0100) begin n_fail++; $display("FAIL svc_ack_ignored_ins: got %b want 0100", in_service); end
      n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL svc_ack_ignored_pend: got %b want 0001", pending); end
      fin_int = 1'b1; tick(); fin_int = 1'b0;
      n_tests++; if (irq_uc !== 1'b1) begin n_fail++; $display("FAIL svc_fin_irq: got %b want 1", irq_uc); end
      n_tests++; if (vector !== VB) begin n_fail++; $display("FAIL svc_fin_vec: got %h want %h", vector, VB); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      fin_int = 1'b1; tick(); fin_int = 1'b0;
`endif
   endtask

   task automatic test_reset_mid();
      int_req = 4'b0100; tick(); int_req = '0;
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      int_req = 4'b1000; tick(); int_req = '0;
      n_tests++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL rmid_pre_pend: got %b want 1000", pending); end
      #2 reset = 1'b1;
      #1;
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rmid_pend: got %b want 0000", pending); end
      n_tests++; if (in_service !== 4'b0000) begin n_fail++; $display("FAIL rmid_ins: got %b want 0000", in_service); end
      n_tests++; if (irq_uc !== 1'b0) begin n_fail++; $display("FAIL rmid_irq: got %b want 0", irq_uc); end
      int_req = 4'b0010;
      #3 reset = 1'b0;
      tick();
      n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL rmid_held_pend: got %b want 0010", pending); end
      n_tests++; if (vector !== VB + 10'd1) begin n_fail++; $display("FAIL rmid_held_vec: got %h want %h", vector, VB + 10'd1); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rmid_held_nornew: got %b want 0000", pending); end
      int_req = '0;
      fin_int = 1'b1; tick(); fin_int = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         int_req = N'($urandom & $urandom);
         mask_we = ($urandom_range(0, 15) == 0);
         mask_d  = N'($urandom);
         int_ack = ($urandom_range(0, 2) == 0);
         fin_int = ($urandom_range(0, 3) == 0);
         tick();
         n_tests++; if (irq_uc !== exp_irq()) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b want %b", k, irq_uc, exp_irq()); end
         n_tests++; if (vector !== exp_vec()) begin n_fail++; $display("FAIL rnd_vec[%0d]: got %h want %h", k, vector, exp_vec()); end
         n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend[%0d]: got %b want %b", k, pending, m_pend); end
         n_tests++; if (in_service !== m_ins) begin n_fail++; $display("FAIL rnd_ins[%0d]: got %b want %b", k, in_service, m_ins); end
      end
      int_req = '0; mask_we = 1'b0; int_ack = 1'b0; fin_int = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_service();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
